// File: rtl/reg_file_scanner.sv
`default_nettype none
// ============================================================================
// reg_file_scanner
//   Reads 8 consecutive register-file nibbles into a display buffer and
//   multiplexes them onto an 8-digit active-low seven-segment display.
//   Option macro: SCAN_AUTO_REFRESH_EN (re-scan from latched base on digit wrap)
// Revision: 1.0 - initial release
// ============================================================================
module reg_file_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] base,
    output logic [6:0] address_r,
    input  logic [3:0] data_r,
    output logic       busy,
    output logic [6:0] sseg,
    output logic [7:0] AN,
    output logic       DP
);

    localparam int c_cnt_w = $clog2(REFRESH_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_load = 1'b1;

`ifdef SCAN_AUTO_REFRESH_EN
    localparam logic c_auto_en = 1'b1;
`else
    localparam logic c_auto_en = 1'b0;
`endif

    logic [0:0]         r_state;
    logic [6:0]         r_base;
    logic [2:0]         r_idx;
    logic [3:0]         r_buf [8];
    logic [c_cnt_w-1:0] r_refresh;
    logic [2:0]         r_digit;
    logic [6:0]         r_sseg;
    logic [7:0]         r_an;
    logic               r_dp;

    logic w_refresh_wrap;
    logic w_digit_wrap;
    logic w_auto_load;

    function automatic logic [6:0] f_hex(input logic [3:0] v);
        case (v)
            4'h0: f_hex = 7'b0000001;
            4'h1: f_hex = 7'b1001111;
            4'h2: f_hex = 7'b0010010;
            4'h3: f_hex = 7'b0000110;
            4'h4: f_hex = 7'b1001100;
            4'h5: f_hex = 7'b0100100;
            4'h6: f_hex = 7'b0100000;
            4'h7: f_hex = 7'b0001111;
            4'h8: f_hex = 7'b0000000;
            4'h9: f_hex = 7'b0000100;
            4'hA: f_hex = 7'b0001000;
            4'hB: f_hex = 7'b1100000;
            4'hC: f_hex = 7'b0110001;
            4'hD: f_hex = 7'b1000010;
            4'hE: f_hex = 7'b0110000;
            default: f_hex = 7'b0111000;
        endcase
    endfunction

    assign w_refresh_wrap = (r_refresh == c_cnt_max);
    assign w_digit_wrap   = w_refresh_wrap && (r_digit == 3'd7);
    assign w_auto_load    = c_auto_en & w_digit_wrap;

    // r_idx rests at 0 in IDLE, so this also holds the latched base there
    assign address_r = r_base + {4'b0000, r_idx};
    assign busy      = (r_state == c_load);
    assign sseg      = r_sseg;
    assign AN        = r_an;
    assign DP        = r_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_base  <= 7'd0;
            r_idx   <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= 4'd0;
            end
        end else if (r_state == c_idle) begin
            if (start) begin
                r_base  <= base;
                r_idx   <= 3'd0;
                r_state <= c_load;
            end else if (w_auto_load) begin
                r_idx   <= 3'd0;
                r_state <= c_load;
            end
        end else begin
            // start is deliberately not looked at while loading
            r_buf[r_idx] <= data_r;
            r_idx        <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
                r_state <= c_idle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_digit   <= 3'd0;
            r_sseg    <= 7'b0000001;
            r_an      <= 8'b11111110;
            r_dp      <= 1'b0;
        end else begin
            r_refresh <= w_refresh_wrap ? '0 : r_refresh + 1'b1;
            if (w_refresh_wrap) begin
                r_digit <= r_digit + 3'd1;
            end
            r_sseg <= f_hex(r_buf[r_digit]);
            r_an   <= ~(8'b00000001 << r_digit);
            r_dp   <= (r_digit != 3'd0);
        end
    end

endmodule
`default_nettype wire

// File: doc/reg_file_scanner.md
REG_FILE_SCANNER -- requirements
Module: reg_file_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per displayed digit (minimum 2).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse, already debounced, that requests a scan.
REQ-005 SHALL have port base  input  7  first register-file address to scan.
REQ-006 SHALL have port address_r  output  7  read address driven to the register file.
REQ-007 SHALL have port data_r  input  4  combinational read data returned for address_r.
REQ-008 SHALL have port busy  output  1  high while a scan is in progress.
REQ-009 SHALL have port sseg  output  7  active-low segments, hex-decoded, for the active digit.
REQ-010 SHALL have port AN  output  8  active-low one-hot digit enable.
REQ-011 SHALL have port DP  output  1  active-low decimal point.

Function
REQ-012 SHALL implement FSM states IDLE and LOAD.
REQ-013 IDLE -> LOAD on start=1; base SHALL be latched into an internal pointer on that edge.
REQ-014 In LOAD, scan index i SHALL count 0..7; address_r = (latched base + i) mod 128, 7-bit wrap (base 126 yields 126,127,0,1,...).
REQ-015 At each clk edge in LOAD, data_r SHALL be captured into buffer[i]; LOAD lasts exactly 8 cycles, then returns to IDLE.
REQ-016 busy SHALL be 1 for exactly the 8 LOAD cycles, 0 otherwise.
REQ-017 start asserted while in LOAD SHALL be ignored; no restart, no latch of new base.
REQ-018 start on the same edge LOAD completes SHALL be ignored; start in IDLE on the following cycle SHALL be accepted.
REQ-019 In IDLE, address_r SHALL hold the latched base.
REQ-020 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index d SHALL advance 0..7 and wrap to 0.
REQ-021 AN SHALL be all ones except bit d = 0; sseg SHALL be the hex segment pattern of buffer[d].
REQ-022 The display SHALL run continuously, independent of the FSM state; buffer entries updated mid-scan SHALL appear immediately.
REQ-023 DP SHALL be 0 when d = 0, marking the base-address digit, and 1 otherwise.
REQ-024 sseg, AN and DP SHALL be registered, so they change one cycle after d or buffer changes.

Reset
REQ-025 On reset: FSM = IDLE, busy = 0, base pointer = 0, address_r = 0, buffer all 0, refresh counter = 0, d = 0.
REQ-026 Reset SHALL take priority over start and abort an in-progress LOAD; buffer entries already captured SHALL be cleared.
REQ-027 In the cycle after reset releases: AN = 11111110, sseg = pattern for 0 (0000001), DP = 0.

Configuration
REQ-028 Macro SCAN_AUTO_REFRESH_EN, when defined: a LOAD from the latched base SHALL start automatically each time d wraps 7 -> 0 while in IDLE, giving a live display; start still works.
REQ-029 Without SCAN_AUTO_REFRESH_EN: LOAD SHALL start only on start; the buffer is frozen between scans.

Verification
REQ-030 With REFRESH_DIV=4, drive reset for 2 cycles then release -> AN=11111110, sseg=0000001, DP=0, busy=0, address_r=0.
REQ-031 With RF model holding addr k = k[3:0], pulse start with base=5 -> busy high 8 cycles; address_r = 5..12; buffer shows 5,6,7,8,9,A,B,C on digits 0..7.
REQ-032 Pulse start with base=126 -> address_r = 126,127,0,1,2,3,4,5, with no carry beyond 7 bits.
REQ-033 Pulse start again 3 cycles into LOAD with base=40 -> ignored; scan completes from the original base; busy falls after 8 cycles total.
REQ-034 Assert reset in LOAD cycle 4 -> next cycle busy=0, FSM in IDLE, all digits display 0.
REQ-035 With SCAN_AUTO_REFRESH_EN defined, change the RF model contents after a scan -> new values appear after the next 7 -> 0 digit wrap with no start pulse; without the macro, the old values persist.
